// File: rtl/door_pkg.sv
// Shared state encoding, requester codes and source-priority helper for the
// automatic-door sequencer.
package door_pkg;

  typedef enum logic [2:0] {
    HOMING  = 3'd0,
    CLOSED  = 3'd1,
    OPENING = 3'd2,
    HOLD    = 3'd3,
    CLOSING = 3'd4,
    BRAKE   = 3'd5,
    FAULT   = 3'd6
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_IN   = 2'd1;
  localparam logic [1:0] SRC_OUT  = 2'd2;
  localparam logic [1:0] SRC_REM  = 2'd3;

  // Fixed priority remote > outside > inside.
  function automatic logic [1:0] src_pick(input logic rin, input logic rout, input logic rrem);
    logic [1:0] s;
    if (rrem) begin
      s = SRC_REM;
    end else if (rout) begin
      s = SRC_OUT;
    end else if (rin) begin
      s = SRC_IN;
    end else begin
      s = SRC_NONE;
    end
    return s;
  endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable saturating down-counter shared by every timed state of the sequencer.
module door_timer
  import door_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/door_sequencer.sv
// Automatic-door motor sequencer: request arbitration, timed hold, auto-close,
// obstruction reversal and travel/sensor fault handling.
module door_sequencer
  import door_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int TRAVEL_MAX  = 64,
  parameter int DEADTIME    = 2,
  parameter int MAX_REV     = 3,
  parameter int CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_in,
  input  logic       req_out,
  input  logic       req_rem,
  input  logic       obstruct,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       fault_clr,
  output logic       UP_M,
  output logic       DN_M,
  output logic       fault,
  output logic [1:0] last_src
);

  localparam int REV_W    = $clog2(MAX_REV + 1);
  localparam int LOAD_MAX = (TRAVEL_MAX > HOLD_CYCLES) ?
                            ((TRAVEL_MAX > DEADTIME) ? TRAVEL_MAX : DEADTIME) :
                            ((HOLD_CYCLES > DEADTIME) ? HOLD_CYCLES : DEADTIME);

  state_t           state_r;
  state_t           state_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic [CNT_W-1:0] cnt_s;
  logic             zero_s;
  logic [REV_W-1:0] rev_cnt_r;
  logic             rev_inc_s;
  logic             rev_clr_s;
  logic             src_upd_s;
  logic             up_m_r;
  logic             dn_m_r;
  logic             fault_r;
  logic [1:0]       last_src_r;
  logic             request_s;
  logic             both_lim_s;
  logic             timer_bad_s;

  assign request_s  = req_in | req_out | req_rem;
  assign both_lim_s = UP_Max & DN_Max;
  // A count above every value we ever load can only come from corruption.
  assign timer_bad_s = (cnt_s > CNT_W'(LOAD_MAX));

  door_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(TRAVEL_MAX)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load_s),
    .load_val(load_val_s),
    .en      (1'b1),
    .cnt     (cnt_s),
    .zero    (zero_s)
  );

  // Next-state, timer load and counter control.
  always_comb begin
    state_s    = state_r;
    load_s     = 1'b0;
    load_val_s = CNT_W'(TRAVEL_MAX);
    rev_inc_s  = 1'b0;
    rev_clr_s  = 1'b0;
    src_upd_s  = 1'b0;
    if ((state_r != FAULT) && (both_lim_s || timer_bad_s)) begin
      state_s = FAULT;
    end else begin
      case (state_r)
        HOMING: begin
          if (DN_Max) begin
            state_s = CLOSED;
          end else if (zero_s) begin
            state_s = FAULT;
          end else begin
            state_s = HOMING;
          end
        end
        CLOSED: begin
          if (request_s && !UP_Max) begin
            state_s    = OPENING;
            load_s     = 1'b1;
            load_val_s = CNT_W'(TRAVEL_MAX);
            rev_clr_s  = 1'b1;
            src_upd_s  = 1'b1;
          end else begin
            state_s = CLOSED;
          end
        end
        OPENING: begin
          if (UP_Max) begin
            state_s    = HOLD;
            load_s     = 1'b1;
            load_val_s = CNT_W'(HOLD_CYCLES);
          end else if (zero_s) begin
            state_s = FAULT;
          end else begin
            state_s = OPENING;
          end
        end
        HOLD: begin
          if (request_s || obstruct) begin
            load_s     = 1'b1;
            load_val_s = CNT_W'(HOLD_CYCLES);
          end else if (zero_s) begin
            state_s    = CLOSING;
            load_s     = 1'b1;
            load_val_s = CNT_W'(TRAVEL_MAX);
          end else begin
            state_s = HOLD;
          end
        end
        CLOSING: begin
          // Reaching the closed limit beats a same-cycle obstruction.
          if (DN_Max) begin
            state_s = CLOSED;
          end else if (obstruct || request_s) begin
            state_s    = BRAKE;
            load_s     = 1'b1;
            load_val_s = CNT_W'(DEADTIME);
            rev_inc_s  = 1'b1;
          end else if (zero_s) begin
            state_s = FAULT;
          end else begin
            state_s = CLOSING;
          end
        end
        BRAKE: begin
          if (zero_s && (rev_cnt_r == REV_W'(MAX_REV))) begin
            state_s = FAULT;
          end else if (zero_s) begin
            state_s    = OPENING;
            load_s     = 1'b1;
            load_val_s = CNT_W'(TRAVEL_MAX);
          end else begin
            state_s = BRAKE;
          end
        end
        FAULT: begin
          if (fault_clr && !both_lim_s) begin
            state_s    = HOMING;
            load_s     = 1'b1;
            load_val_s = CNT_W'(TRAVEL_MAX);
          end else begin
            state_s = FAULT;
          end
        end
        default: begin
          state_s = FAULT;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= HOMING;
    end else begin
      state_r <= state_s;
    end
  end

  // Outputs are the decode of the state being entered, so they track state_r exactly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      up_m_r  <= 1'b0;
      dn_m_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      up_m_r  <= (state_s == OPENING);
      dn_m_r  <= (state_s == CLOSING) || (state_s == HOMING);
      fault_r <= (state_s == FAULT);
    end
  end

  // Consecutive-reversal counter, cleared on each fresh open from CLOSED.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rev_cnt_r <= {REV_W{1'b0}};
    end else if (rev_clr_s) begin
      rev_cnt_r <= {REV_W{1'b0}};
    end else if (rev_inc_s && (rev_cnt_r != REV_W'(MAX_REV))) begin
      rev_cnt_r <= rev_cnt_r + {{(REV_W-1){1'b0}}, 1'b1};
    end else begin
      rev_cnt_r <= rev_cnt_r;
    end
  end

  // Requester that triggered the most recent open.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_src_r <= SRC_NONE;
    end else if (src_upd_s) begin
      last_src_r <= src_pick(req_in, req_out, req_rem);
    end else begin
      last_src_r <= last_src_r;
    end
  end

  assign UP_M     = up_m_r;
  assign DN_M     = dn_m_r;
  assign fault    = fault_r;
  assign last_src = last_src_r;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed plus randomized bench for door_sequencer against a behavioural door model.
module tb_door_sequencer;

  localparam int HOLD   = 16;
  localparam int TRAVEL = 64;
  localparam int DEAD   = 2;
  localparam int MAXREV = 3;
  localparam int POSMAX = 30;

  localparam int MD_HOME  = 10;
  localparam int MD_SHUT  = 11;
  localparam int MD_RISE  = 12;
  localparam int MD_DWELL = 13;
  localparam int MD_FALL  = 14;
  localparam int MD_PAUSE = 15;
  localparam int MD_ERR   = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       req_in = 1'b0, req_out = 1'b0, req_rem = 1'b0;
  logic       obstruct = 1'b0, UP_Max = 1'b0, DN_Max = 1'b0, fault_clr = 1'b0;
  logic       UP_M, DN_M, fault;
  logic [1:0] last_src;

  int         checks = 0;
  int         errors = 0;
  int         m_mode, m_left, m_rev;
  logic [1:0] m_src;
  logic       exp_up, exp_dn, exp_fault;
  int         pos;
  int         rate;

  door_sequencer dut (
    .CLK(CLK), .RST(RST), .req_in(req_in), .req_out(req_out), .req_rem(req_rem),
    .obstruct(obstruct), .UP_Max(UP_Max), .DN_Max(DN_Max), .fault_clr(fault_clr),
    .UP_M(UP_M), .DN_M(DN_M), .fault(fault), .last_src(last_src)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, "_up"},    {1'b0, UP_M},  {1'b0, exp_up});
    check({ph, "_dn"},    {1'b0, DN_M},  {1'b0, exp_dn});
    check({ph, "_fault"}, {1'b0, fault}, {1'b0, exp_fault});
    check({ph, "_src"},   last_src,      m_src);
  endtask

  task automatic model_reset();
    m_mode = MD_HOME; m_left = TRAVEL; m_rev = 0; m_src = 2'd0;
    exp_up = 1'b0; exp_dn = 1'b0; exp_fault = 1'b0;
  endtask

  // Door behaviour for one clock edge, from the sampled inputs.
  task automatic model_edge();
    int  nxt;
    int  ld;
    bit  req;
    bit  both;
    req  = req_in || req_out || req_rem;
    both = UP_Max && DN_Max;
    nxt  = m_mode;
    ld   = -1;
    if (m_mode != MD_ERR && both) nxt = MD_ERR;
    else begin
      case (m_mode)
        MD_HOME: if (DN_Max) nxt = MD_SHUT; else if (m_left == 0) nxt = MD_ERR;
        MD_SHUT: if (req && !UP_Max) begin
          nxt = MD_RISE; ld = TRAVEL; m_rev = 0;
          m_src = req_rem ? 2'd3 : (req_out ? 2'd2 : 2'd1);
        end
        MD_RISE: if (UP_Max) begin nxt = MD_DWELL; ld = HOLD; end
                 else if (m_left == 0) nxt = MD_ERR;
        MD_DWELL: if (req || obstruct) ld = HOLD;
                  else if (m_left == 0) begin nxt = MD_FALL; ld = TRAVEL; end
        MD_FALL: if (DN_Max) nxt = MD_SHUT;
                 else if (obstruct || req) begin nxt = MD_PAUSE; ld = DEAD; m_rev++; end
                 else if (m_left == 0) nxt = MD_ERR;
        MD_PAUSE: if (m_left == 0) begin
          if (m_rev >= MAXREV) nxt = MD_ERR;
          else begin nxt = MD_RISE; ld = TRAVEL; end
        end
        MD_ERR: if (fault_clr && !both) begin nxt = MD_HOME; ld = TRAVEL; end
        default: nxt = MD_ERR;
      endcase
    end
    m_left    = (ld >= 0) ? ld : ((m_left > 0) ? m_left - 1 : 0);
    m_mode    = nxt;
    exp_up    = (nxt == MD_RISE);
    exp_dn    = (nxt == MD_HOME) || (nxt == MD_FALL);
    exp_fault = (nxt == MD_ERR);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    model_reset();
    #1;
    check_outputs("rst");
    @(posedge CLK);
    #1;
    check_outputs("rst_hold");
    RST = 1'b1;
  endtask

  initial begin
    do_reset();

    // Homing until the closed limit appears
    tick();
    check("t1_homing_dn", {1'b0, DN_M}, 2'd1);
    run(9);
    DN_Max = 1'b1;
    tick();
    check("t1_closed_dn", {1'b0, DN_M}, 2'd0);

    // Remote open, hold, auto-close
    req_rem = 1'b1; tick(); req_rem = 1'b0; DN_Max = 1'b0;
    check("t2_open_up", {1'b0, UP_M}, 2'd1);
    check("t2_src_rem", last_src, 2'd3);
    run(4);
    UP_Max = 1'b1; tick();
    check("t2_hold_up", {1'b0, UP_M}, 2'd0);
    run(HOLD);
    check("t2_hold_last", {1'b0, DN_M}, 2'd0);
    tick();
    check("t2_close_dn", {1'b0, DN_M}, 2'd1);
    UP_Max = 1'b0; run(5);
    DN_Max = 1'b1; tick();
    check("t2_reclosed", {1'b0, DN_M}, 2'd0);

    // Repeated inside requests keep the door open
    req_in = 1'b1; tick(); req_in = 1'b0; DN_Max = 1'b0;
    check("t3_src_in", last_src, 2'd1);
    run(3);
    UP_Max = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin
      run(9);
      req_in = 1'b1; tick(); req_in = 1'b0;
      check("t3_stay_open", {1'b0, DN_M}, 2'd0);
    end
    run(HOLD);
    check("t3_hold_last", {1'b0, DN_M}, 2'd0);
    tick();
    check("t3_close_dn", {1'b0, DN_M}, 2'd1);

    // Obstruction reversals until the limit trips
    for (int r = 1; r <= MAXREV; r++) begin
      UP_Max = 1'b0;
      obstruct = 1'b1; tick(); obstruct = 1'b0;
      check("t4_brake_up", {1'b0, UP_M}, 2'd0);
      check("t4_brake_dn", {1'b0, DN_M}, 2'd0);
      run(DEAD);
      check("t4_brake_off", {1'b0, UP_M}, 2'd0);
      tick();
      if (r < MAXREV) begin
        check("t4_reopen", {1'b0, UP_M}, 2'd1);
        run(2);
        UP_Max = 1'b1; tick();
        run(HOLD + 1);
        check("t4_reclose", {1'b0, DN_M}, 2'd1);
      end else begin
        check("t4_rev_fault", {1'b0, fault}, 2'd1);
        check("t4_rev_motor", {UP_M, DN_M}, 2'd0);
      end
    end

    // Opening travel timeout
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    DN_Max = 1'b1; tick();
    req_out = 1'b1; tick(); req_out = 1'b0; DN_Max = 1'b0;
    check("t5_src_out", last_src, 2'd2);
    run(TRAVEL);
    check("t5_no_fault_yet", {1'b0, fault}, 2'd0);
    tick();
    check("t5_travel_fault", {1'b0, fault}, 2'd1);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("t5_clr_homing", {1'b0, DN_M}, 2'd1);

    // Both limits active
    DN_Max = 1'b1; tick();
    UP_Max = 1'b1; tick();
    check("t6_both_fault", {1'b0, fault}, 2'd1);
    fault_clr = 1'b1; run(3);
    check("t6_clr_blocked", {1'b0, fault}, 2'd1);
    UP_Max = 1'b0; tick();
    check("t6_clr_homing", {1'b0, DN_M}, 2'd1);
    fault_clr = 1'b0; tick();

    // Reset in the middle of travel
    req_rem = 1'b1; tick(); req_rem = 1'b0; DN_Max = 1'b0;
    run(3);
    check("t7_moving", {1'b0, UP_M}, 2'd1);
    do_reset();
    check("t7_motor_drop", {UP_M, DN_M}, 2'd0);
    run(2);

    // Randomized traffic with a simple door plant
    pos = 15;
    for (int c = 0; c < 4000; c++) begin
      rate = (((c / 400) % 2) == 1) ? 15 : 60;
      if (exp_up) pos += int'($urandom_range(0, 1));
      if (exp_dn) pos -= int'($urandom_range(0, 1));
      if (pos < 0) pos = 0;
      if (pos > POSMAX) pos = POSMAX;
      UP_Max    = (pos == POSMAX);
      DN_Max    = (pos == 0);
      if ($urandom_range(0, 299) == 0) begin UP_Max = 1'b1; DN_Max = 1'b1; end
      req_in    = ($urandom_range(0, rate - 1) == 0);
      req_out   = ($urandom_range(0, rate - 1) == 0);
      req_rem   = ($urandom_range(0, rate - 1) == 0);
      obstruct  = ($urandom_range(0, 29) == 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
